// File: rtl/iic_master_byte_ctrl_if.sv
// ----------------------------------------------------------------------------
// iic_master_byte_ctrl_if
// Bundles the host register bus and the I2C pad signals of the byte controller.
//   adr_in    : register select (00 TXR, 01 RXR, 10 SR, 11 CTR)
//   data_in   : register write data
//   cs        : one-clk write strobe, captured with adr_in/data_in
//   data_out  : combinational read of the register selected by adr_in
//   irq       : SR.DONE & CTR.IEN
//   scl_i/sda_i         : pad inputs
//   scl_oen_n/sda_oen_n : 0 pulls the line low, 1 releases it
//   scl_o/sda_o         : pad output values, always 0 (open-drain)
// Modports: master = the controller, slave = host/pad environment.
// ----------------------------------------------------------------------------
interface iic_master_byte_ctrl_if;
    logic [1:0] adr_in;
    logic [7:0] data_in;
    logic       cs;
    logic [7:0] data_out;
    logic       irq;
    logic       scl_i;
    logic       sda_i;
    logic       scl_oen_n;
    logic       sda_oen_n;
    logic       scl_o;
    logic       sda_o;

    modport master (
        input  adr_in, data_in, cs, scl_i, sda_i,
        output data_out, irq, scl_oen_n, sda_oen_n, scl_o, sda_o
    );

    modport slave (
        output adr_in, data_in, cs, scl_i, sda_i,
        input  data_out, irq, scl_oen_n, sda_oen_n, scl_o, sda_o
    );
endinterface

// File: rtl/iic_master_byte_ctrl.sv
// ----------------------------------------------------------------------------
// iic_master_byte_ctrl
// I2C master byte controller with a TXR/RXR/SR/CTR register map. One CTR
// write runs any combination of START, byte write or byte read, and STOP.
// Each bus bit is four phases (A,B: SCL low; C,D: SCL high) of QDIV clocks.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : iic_master_byte_ctrl_if.master (register bus + SCL/SDA pads)
// Parameters:
//   QDIV  : clk cycles per quarter SCL period (>=1)
//   CNT_W : width of the quarter-period counter
// Optional feature: define IIC_CLK_STRETCH_EN to let a slave stretch SCL
// (quarter counter freezes in phase C while scl_i is low). Without it scl_i
// is ignored.
// ----------------------------------------------------------------------------
module iic_master_byte_ctrl #(
    parameter int QDIV  = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    iic_master_byte_ctrl_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_ACK, S_STOP} state_t;

    localparam logic [CNT_W-1:0] QLAST = CNT_W'(QDIV - 1);

    state_t           state, state_nxt;
    logic [7:0]       txr, rxr, ctr, sh;
    logic             busy, rxack, done;
    logic             held;          // SCL parked low after a command without STOP
    logic [CNT_W-1:0] qcnt;
    logic [1:0]       phase;
    logic [2:0]       bit_cnt;

    logic ctr_sel, cmd_go, abort, tick, q_last, stage_end, finish;
    logic wr_mode, rd_mode;
    logic scl_n, sda_n;

    assign ctr_sel = bus.cs && (bus.adr_in == 2'b11);
    assign cmd_go  = ctr_sel && !busy && bus.data_in[7] && (|bus.data_in[3:0]);
    assign abort   = ctr_sel && busy && !bus.data_in[7];
    assign wr_mode = ctr[2];
    assign rd_mode = ctr[3] && !ctr[2];   // WR wins when both are set

`ifdef IIC_CLK_STRETCH_EN
    // Freeze the quarter counter while a slave holds SCL low in phase C.
    assign tick = !((phase == 2'd2) && !bus.scl_i);
`else
    assign tick = 1'b1;
`endif

    assign q_last    = (qcnt == QLAST);
    assign stage_end = (state != S_IDLE) && tick && q_last && (phase == 2'd3) &&
                       ((state != S_DATA) || (bit_cnt == 3'd0));
    assign finish    = stage_end && !abort && (state_nxt == S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: unused stages are skipped
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_go)
                         state_nxt = bus.data_in[0] ? S_START :
                                     (bus.data_in[2] || bus.data_in[3]) ? S_DATA : S_STOP;
            S_START: if (stage_end)
                         state_nxt = (ctr[2] || ctr[3]) ? S_DATA :
                                     ctr[1] ? S_STOP : S_IDLE;
            S_DATA:  if (stage_end) state_nxt = S_ACK;
            S_ACK:   if (stage_end) state_nxt = ctr[1] ? S_STOP : S_IDLE;
            S_STOP:  if (stage_end) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // Line drive per state and phase
    always_comb begin
        scl_n = 1'b1;
        sda_n = 1'b1;
        case (state)
            S_IDLE:  scl_n = !held;
            S_START: case (phase)
                         // From the held-low state, phase A only releases SDA.
                         2'd0:    scl_n = !held;
                         2'd2:    sda_n = 1'b0;
                         2'd3:    begin scl_n = 1'b0; sda_n = 1'b0; end
                         default: ;
                     endcase
            S_DATA:  begin
                         scl_n = phase[1];
                         sda_n = wr_mode ? txr[bit_cnt] : 1'b1;
                     end
            S_ACK:   begin
                         scl_n = phase[1];
                         sda_n = wr_mode ? 1'b1 : ctr[4];
                     end
            S_STOP:  case (phase)
                         2'd0:    begin scl_n = 1'b0; sda_n = 1'b0; end
                         2'd1:    sda_n = 1'b0;
                         default: ;
                     endcase
            default: ;
        endcase
    end

    assign bus.scl_oen_n = scl_n;
    assign bus.sda_oen_n = sda_n;
    assign bus.scl_o     = 1'b0;
    assign bus.sda_o     = 1'b0;
    assign bus.irq       = done && ctr[6];

    always_comb begin
        case (bus.adr_in)
            2'b00:   bus.data_out = txr;
            2'b01:   bus.data_out = rxr;
            2'b10:   bus.data_out = {5'b0, done, rxack, busy};
            default: bus.data_out = ctr;
        endcase
    end

    // Registers, timing counters and sampling
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txr     <= '0;
            rxr     <= '0;
            ctr     <= '0;
            busy    <= 1'b0;
            rxack   <= 1'b0;
            done    <= 1'b0;
            held    <= 1'b0;
            qcnt    <= '0;
            phase   <= '0;
            bit_cnt <= '0;
        end else begin
            if (bus.cs && (bus.adr_in == 2'b00) && !busy) txr <= bus.data_in;
            if (bus.cs && (bus.adr_in == 2'b10))          done <= 1'b0;
            if (ctr_sel && (!busy || !bus.data_in[7]))    ctr <= bus.data_in;

            if (cmd_go) begin
                busy    <= 1'b1;
                done    <= 1'b0;
                qcnt    <= '0;
                phase   <= '0;
                bit_cnt <= 3'd7;
            end else if (abort) begin
                busy    <= 1'b0;
                held    <= 1'b0;
                qcnt    <= '0;
                phase   <= '0;
            end else if ((state != S_IDLE) && tick) begin
                if (q_last) begin
                    qcnt  <= '0;
                    phase <= phase + 2'd1;
                    if ((phase == 2'd3) && (state == S_DATA)) bit_cnt <= bit_cnt - 3'd1;
                end else begin
                    qcnt <= qcnt + 1'b1;
                end
                // Sample SDA on the last clk of phase C
                if ((state == S_DATA) && (phase == 2'd2) && q_last && rd_mode)
                    sh <= {sh[6:0], bus.sda_i};
                if ((state == S_ACK) && (phase == 2'd2) && q_last && wr_mode)
                    rxack <= bus.sda_i;
                if (stage_end && (state == S_DATA) && rd_mode) rxr <= sh;
                if (stage_end) held <= (state != S_STOP);
                if (finish) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    ctr[3:0] <= 4'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_iic_master_byte_ctrl.sv
module tb_iic_master_byte_ctrl;
    localparam int QDIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iic_master_byte_ctrl_if bus();

    iic_master_byte_ctrl #(.QDIV(QDIV), .CNT_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    // Open-drain wiring with the slave model
    logic sl_drv = 1'b1;
    logic sl_scl = 1'b1;
    assign bus.sda_i = bus.sda_oen_n & sl_drv;
    assign bus.scl_i = bus.scl_oen_n & sl_scl;

    int n_chk = 0;
    int n_fail = 0;
    bit held_m = 1'b0;

    // Slave script: one SDA value per bit, presented after each SCL fall
    int sl_arr[256];
    int sl_wr = 0, sl_rd = 0;
    int load_req = 0, load_ack = 0, flush_req = 0, flush_ack = 0;

    // Bus monitor: 0/1 data bits (taken at SCL fall), 2 = START, 3 = STOP
    int   mon_q[$];
    logic scl_prev = 1'b1, sda_prev = 1'b1;
    bit   hi_evt = 1'b0;

    always @(negedge clk) begin
        logic scl_l, sda_l;
        bit   fall;
        scl_l = bus.scl_i;
        sda_l = bus.sda_i;
        fall  = scl_prev && !scl_l;
        if (scl_prev && scl_l && sda_prev && !sda_l) begin mon_q.push_back(2); hi_evt = 1'b1; end
        if (scl_prev && scl_l && !sda_prev && sda_l) begin mon_q.push_back(3); hi_evt = 1'b1; end
        if (fall) begin
            if (!hi_evt) mon_q.push_back(int'(sda_prev));
            hi_evt = 1'b0;
        end
        if (flush_req != flush_ack) begin
            flush_ack = flush_req;
            sl_rd = sl_wr;
            sl_drv = 1'b1;
        end else if (fall || (load_req != load_ack)) begin
            load_ack = load_req;
            if (sl_rd != sl_wr) begin
                sl_drv = sl_arr[sl_rd % 256][0];
                sl_rd++;
            end else begin
                sl_drv = 1'b1;
            end
        end
        scl_prev = scl_l;
        sda_prev = sda_l;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.adr_in = a; bus.data_in = d; bus.cs = 1'b1;
        @(negedge clk);
        bus.cs = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [7:0] d);
        bus.adr_in = a;
        #1;
        d = bus.data_out;
    endtask

    task automatic slave_load(input int bits[$], input bit now);
        foreach (bits[i]) begin sl_arr[sl_wr % 256] = bits[i]; sl_wr++; end
        if (now) load_req++;
    endtask

    task automatic cmp_events(input string nm, input int idx, input int exp[$]);
        string sa, se;
        bit ok;
        sa = ""; se = "";
        ok = ((mon_q.size() - idx) == exp.size());
        for (int i = idx; i < mon_q.size(); i++) sa = {sa, $sformatf("%0d", mon_q[i])};
        foreach (exp[i]) begin
            se = {se, $sformatf("%0d", exp[i])};
            if (ok && (mon_q[idx + i] != exp[i])) ok = 1'b0;
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_events: actual %s expected %s", nm, sa, se);
        end
    endtask

    // Wait for SR.DONE; returns clk edges counted from the CTR capture edge
    task automatic wait_done(output int lat);
        lat = 0;
        bus.adr_in = 2'b10;
        #1;
        while ((bus.data_out[2] !== 1'b1) && (lat < 3000)) begin
            @(negedge clk);
            lat++;
            #1;
        end
    endtask

    // One command against the reference rules: expected bus events, latency
    // (4 phases per START/STOP, 36 per byte incl. 9th bit), RXR/RXACK/irq.
    task automatic run_cmd(input bit sta, input bit wr, input bit sto, input bit ack,
                           input bit ien, input logic [7:0] tx, input logic [7:0] sb,
                           input bit sack, input string nm);
        int bits[$];
        int exp[$];
        int idx, lat;
        logic [7:0] r;
        bit rd;
        rd = !wr;
        if (wr) reg_wr(2'b00, tx);
        for (int i = 7; i >= 0; i--) bits.push_back(wr ? 1 : int'(sb[i]));
        bits.push_back(wr ? int'(sack) : 1);
        slave_load(bits, !sta);
        idx = mon_q.size();
        reg_wr(2'b11, {1'b1, ien, 1'b0, ack, rd, wr, sto, sta});
        wait_done(lat);
        check({nm, "_latency"}, lat, QDIV * (4 * int'(sta) + 36 + 4 * int'(sto)));
        repeat (4) @(negedge clk);
        #1;
        if (sta) exp.push_back(2);
        for (int i = 7; i >= 0; i--) exp.push_back(wr ? int'(tx[i]) : int'(sb[i]));
        exp.push_back(wr ? int'(sack) : int'(ack));
        if (sto) exp.push_back(3);
        cmp_events(nm, idx, exp);
        if (rd) begin
            reg_rd(2'b01, r);
            check({nm, "_rxr"}, r, sb);
        end else begin
            reg_rd(2'b10, r);
            check({nm, "_rxack"}, r[1], sack);
        end
        check({nm, "_irq"}, bus.irq, ien);
        held_m = !sto;
    endtask

    typedef struct {
        bit         cs;
        logic [1:0] adr;
        logic [7:0] din;
        logic [1:0] radr;
        logic [7:0] exp;
        bit         irq;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [7:0] r;
        int lat, idx;
        bus.adr_in = 2'b00; bus.data_in = 8'h00; bus.cs = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Register-level vectors (idle controller)
        vt[0] = '{0, 2'd0, 8'h00, 2'd0, 8'h00, 0};
        vt[1] = '{0, 2'd0, 8'h00, 2'd1, 8'h00, 0};
        vt[2] = '{0, 2'd0, 8'h00, 2'd2, 8'h00, 0};
        vt[3] = '{0, 2'd0, 8'h00, 2'd3, 8'h00, 0};
        vt[4] = '{1, 2'd0, 8'h5A, 2'd0, 8'h5A, 0};
        vt[5] = '{1, 2'd3, 8'hC0, 2'd3, 8'hC0, 0};
        vt[6] = '{0, 2'd0, 8'h00, 2'd2, 8'h00, 0};
        vt[7] = '{1, 2'd1, 8'h77, 2'd1, 8'h00, 0};
        vt[8] = '{1, 2'd3, 8'h0F, 2'd2, 8'h00, 0};
        vt[9] = '{1, 2'd3, 8'h00, 2'd3, 8'h00, 0};
        foreach (vt[i]) begin
            @(negedge clk);
            bus.cs = vt[i].cs; bus.adr_in = vt[i].adr; bus.data_in = vt[i].din;
            @(negedge clk);
            bus.cs = 1'b0;
            reg_rd(vt[i].radr, r);
            check($sformatf("vec%0d_data", i), r, vt[i].exp);
            check($sformatf("vec%0d_irq", i), bus.irq, vt[i].irq);
        end

        // START + write A5, slave ACKs
        run_cmd(1, 1, 0, 0, 0, 8'hA5, 8'h00, 0, "wrA5");
        // Read 3C from held-low state with NACK and STOP
        run_cmd(0, 0, 1, 1, 0, 8'h00, 8'h3C, 0, "rd3C");
        reg_rd(2'b11, r);
        check("ctr_selfclear", r, 8'h90);

        // Writes while busy, then abort with CTR=00
        reg_wr(2'b00, 8'h11);
        reg_wr(2'b11, 8'h85);
        repeat (10) @(negedge clk);
        reg_wr(2'b00, 8'hFF);
        reg_rd(2'b00, r);
        check("busy_txr_kept", r, 8'h11);
        reg_rd(2'b10, r);
        check("busy_set", r[0], 1'b1);
        reg_wr(2'b11, 8'h00);
        reg_rd(2'b10, r);
        check("abort_busy", r[0], 1'b0);
        check("abort_lines", {bus.scl_oen_n, bus.sda_oen_n}, 2'b11);
        flush_req++;
        held_m = 1'b0;
        repeat (4) @(negedge clk);

        // No slave: RXACK=1, irq with IEN, then SR write clears DONE
        run_cmd(1, 1, 1, 0, 1, 8'h3C, 8'h00, 1, "noslave");
        reg_wr(2'b10, 8'h00);
        reg_rd(2'b10, r);
        check("sr_clear_done", r[2], 1'b0);
        check("sr_clear_irq", bus.irq, 1'b0);

`ifdef IIC_CLK_STRETCH_EN
        begin
            int bits[$];
            int exp[$];
            int falls, rises, left;
            logic oen_p;
            reg_wr(2'b00, 8'h96);
            for (int i = 0; i < 8; i++) bits.push_back(1);
            bits.push_back(0);
            slave_load(bits, 1'b0);
            idx = mon_q.size();
            reg_wr(2'b11, 8'h85);
            lat = 0; falls = 0; rises = 0; left = 0; oen_p = 1'b1;
            bus.adr_in = 2'b10;
            #1;
            while ((bus.data_out[2] !== 1'b1) && (lat < 3000)) begin
                @(negedge clk);
                lat++;
                if (left > 0) begin
                    left--;
                    if (left == 0) sl_scl = 1'b1;
                end
                if (oen_p && !bus.scl_oen_n) begin
                    falls++;
                    if (falls == 5) sl_scl = 1'b0;   // bit 3 begins
                end
                if (!oen_p && bus.scl_oen_n) begin
                    rises++;
                    if (rises == 5) left = 20;       // master released SCL in bit 3
                end
                oen_p = bus.scl_oen_n;
                #1;
            end
            sl_scl = 1'b1;
            check("stretch_latency", lat, 40 * QDIV + 20);
            repeat (4) @(negedge clk);
            exp = '{2, 1, 0, 0, 1, 0, 1, 1, 0, 0};
            cmp_events("stretch", idx, exp);
            held_m = 1'b1;
        end
`endif

        // Randomized commands against the reference rules
        for (int n = 0; n < 25; n++) begin
            bit sta, wr, sto, ack, ien, sack;
            logic [7:0] tx, sb;
            wr   = 1'($urandom_range(0, 1));
            sta  = !held_m || 1'($urandom_range(0, 1));
            sto  = 1'($urandom_range(0, 1));
            ack  = 1'($urandom_range(0, 1));
            ien  = 1'($urandom_range(0, 1));
            sack = 1'($urandom_range(0, 1));
            tx   = 8'($urandom);
            sb   = 8'($urandom);
            run_cmd(sta, wr, sto, ack, ien, tx, sb, sack, $sformatf("rnd%0d", n));
        end

        // Reset in the middle of a byte
        if (held_m) run_cmd(0, 0, 1, 0, 0, 8'h00, 8'hC3, 0, "rdC3");
        else        run_cmd(1, 0, 1, 0, 0, 8'h00, 8'hC3, 0, "rdC3");
        reg_wr(2'b00, 8'h5A);
        reg_wr(2'b11, 8'h85);
        repeat (72) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_lines", {bus.scl_oen_n, bus.sda_oen_n}, 2'b11);
        reg_rd(2'b10, r);
        check("rst_sr", r, 8'h00);
        reg_rd(2'b01, r);
        check("rst_rxr", r, 8'h00);
        reg_rd(2'b00, r);
        check("rst_txr", r, 8'h00);
        flush_req++;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
